// File: rtl/tdm_pkg.sv
// Shared definitions for the 2-channel TDM mux/demux pair: slot-tracking
// state encoding and the default sample/counter widths both sides agree on.
package tdm_pkg;

   localparam int TDM_WIDTH = 8;
   localparam int TDM_CNT_W = 8;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      WANT_B = 2'b01,
      WANT_A = 2'b10
   } tdm_state_t;

endpackage

// File: rtl/tdm_demux_2ch.sv
// Splits an interleaved A/B sample stream back into two registered channels,
// using the sync flag on A slots to acquire and police slot alignment.
module tdm_demux_2ch
   import tdm_pkg::*;
#(
   parameter int WIDTH      = TDM_WIDTH,
   parameter int CNT_W      = TDM_CNT_W,
   parameter bit SYNC_EVERY = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             a_valid,
   output logic             b_valid,
   output logic             pair_valid,
   output logic             sync_err,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             locked
);

   tdm_state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         locked     <= 1'b0;
         a          <= '0;
         b          <= '0;
         a_valid    <= 1'b0;
         b_valid    <= 1'b0;
         pair_valid <= 1'b0;
         sync_err   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         a_valid    <= 1'b0;
         b_valid    <= 1'b0;
         pair_valid <= 1'b0;
         sync_err   <= 1'b0;
         if (din_valid) begin
            case (state)
               HUNT: begin
                  // Non-sync samples while hunting are silently discarded.
                  if (sync) begin
                     a       <= din;
                     a_valid <= 1'b1;
                     state   <= WANT_B;
                     locked  <= 1'b1;
                  end
               end
               WANT_B: begin
                  if (sync) begin
                     // A arrived twice: realign onto the newer A, no pair counted.
                     sync_err <= 1'b1;
                     a        <= din;
                     a_valid  <= 1'b1;
                  end else begin
                     b          <= din;
                     b_valid    <= 1'b1;
                     pair_valid <= 1'b1;
                     frame_cnt  <= frame_cnt + CNT_W'(1);
                     state      <= WANT_A;
                  end
               end
               WANT_A: begin
                  if (sync || !SYNC_EVERY) begin
                     a       <= din;
                     a_valid <= 1'b1;
                     state   <= WANT_B;
                  end else begin
                     sync_err <= 1'b1;
                     state    <= HUNT;
                     locked   <= 1'b0;
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Directed bench for tdm_demux_2ch: one instance with SYNC_EVERY=1 and one
// with SYNC_EVERY=0 share the same stimulus.
module tb_tdm_demux_2ch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       sync = 1'b0;

   logic [7:0] a1, b1, cnt1;
   logic       av1, bv1, pv1, err1, lk1;
   logic [7:0] a0, b0, cnt0;
   logic       av0, bv0, pv0, err0, lk0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tdm_demux_2ch #(.WIDTH(8), .CNT_W(8), .SYNC_EVERY(1'b1)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
      .a(a1), .b(b1), .a_valid(av1), .b_valid(bv1), .pair_valid(pv1),
      .sync_err(err1), .frame_cnt(cnt1), .locked(lk1)
   );

   tdm_demux_2ch #(.WIDTH(8), .CNT_W(8), .SYNC_EVERY(1'b0)) dut_s0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
      .a(a0), .b(b0), .a_valid(av0), .b_valid(bv0), .pair_valid(pv0),
      .sync_err(err0), .frame_cnt(cnt0), .locked(lk0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one valid sample for one edge, then return #1 after that edge.
   task automatic send(input logic [7:0] d, input logic s);
      @(negedge clk);
      din       = d;
      din_valid = 1'b1;
      sync      = s;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      sync      = 1'b0;
   endtask

   // Idle cycle with sync held high and junk on din; nothing may react.
   task automatic gap(input string tag);
      @(negedge clk);
      din       = 8'hEE;
      din_valid = 1'b0;
      sync      = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, "_pulses"}, {av1, bv1, pv1, err1}, 4'b0000);
      sync = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_clean(input string tag, input int gaps);
      send(8'h11, 1'b1);
      check_eq({tag, "_a0"}, a1, 8'h11);
      check_eq({tag, "_av0"}, av1, 1'b1);
      check_eq({tag, "_lock0"}, lk1, 1'b1);
      check_eq({tag, "_bv0"}, bv1, 1'b0);
      for (int g = 0; g < gaps; g++) gap(tag);
      send(8'h22, 1'b0);
      check_eq({tag, "_b0"}, b1, 8'h22);
      check_eq({tag, "_bvpv0"}, {bv1, pv1, av1}, 3'b110);
      check_eq({tag, "_cnt1"}, cnt1, 8'd1);
      for (int g = 0; g < gaps; g++) gap(tag);
      send(8'h33, 1'b1);
      check_eq({tag, "_a1"}, a1, 8'h33);
      check_eq({tag, "_bhold"}, b1, 8'h22);
      for (int g = 0; g < gaps; g++) gap(tag);
      send(8'h44, 1'b0);
      check_eq({tag, "_b1"}, b1, 8'h44);
      check_eq({tag, "_ahold"}, a1, 8'h33);
      check_eq({tag, "_cnt2"}, cnt1, 8'd2);
      check_eq({tag, "_err"}, err1, 1'b0);
      @(posedge clk);
      #1;
      check_eq({tag, "_pulse_end"}, {av1, bv1, pv1, err1}, 4'b0000);
      check_eq({tag, "_cnt_hold"}, cnt1, 8'd2);
   endtask

   initial begin
      logic saw_err;

      // Reset state
      #12;
      check_eq("rst_a", a1, 8'h00);
      check_eq("rst_b", b1, 8'h00);
      check_eq("rst_pulses", {av1, bv1, pv1, err1}, 4'b0000);
      check_eq("rst_cnt", cnt1, 8'h00);
      check_eq("rst_lock", lk1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1: clean stream
      run_clean("s1", 0);

      // Scenario 2: valid gaps with sync asserted while idle
      do_reset();
      run_clean("s2", 3);

      // Scenario 3: A arrives twice
      do_reset();
      send(8'hA0, 1'b1);
      send(8'hA1, 1'b1);
      check_eq("s3_err", err1, 1'b1);
      check_eq("s3_a", a1, 8'hA1);
      check_eq("s3_av", av1, 1'b1);
      check_eq("s3_lock", lk1, 1'b1);
      check_eq("s3_cnt0", cnt1, 8'd0);
      send(8'hB1, 1'b0);
      check_eq("s3_b", b1, 8'hB1);
      check_eq("s3_cnt1", cnt1, 8'd1);
      check_eq("s3_err_clr", err1, 1'b0);

      // Scenario 4: missing sync on an A slot
      do_reset();
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      check_eq("s4_err", err1, 1'b1);
      check_eq("s4_lock", lk1, 1'b0);
      check_eq("s4_a", a1, 8'h01);
      check_eq("s4_av", av1, 1'b0);
      check_eq("s4n_a", a0, 8'h03);
      check_eq("s4n_av", av0, 1'b1);
      check_eq("s4n_err", err0, 1'b0);
      check_eq("s4n_lock", lk0, 1'b1);

      // Scenario 5: counter wrap over 256 pairs
      do_reset();
      saw_err = 1'b0;
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 1'b1);
         saw_err |= err1;
         send(8'(~i), 1'b0);
         saw_err |= err1;
         if (i == 254) check_eq("s5_cnt255", cnt1, 8'hFF);
      end
      check_eq("s5_cnt_wrap", cnt1, 8'h00);
      check_eq("s5_no_err", saw_err, 1'b0);
      check_eq("s5_lock", lk1, 1'b1);

      // Scenario 6: asynchronous reset between A and B slots
      do_reset();
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b1);
      check_eq("s6_pre_cnt", cnt1, 8'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("s6_async_a", a1, 8'h00);
      check_eq("s6_async_b", b1, 8'h00);
      check_eq("s6_async_cnt", cnt1, 8'h00);
      check_eq("s6_async_lock", lk1, 1'b0);
      check_eq("s6_async_av", av1, 1'b0);
      rst_n = 1'b1;
      send(8'h55, 1'b0);
      check_eq("s6_drop_a", a1, 8'h00);
      check_eq("s6_drop_av", av1, 1'b0);
      check_eq("s6_drop_lock", lk1, 1'b0);
      send(8'h66, 1'b1);
      check_eq("s6_a", a1, 8'h66);
      send(8'h77, 1'b0);
      check_eq("s6_b", b1, 8'h77);
      check_eq("s6_cnt", cnt1, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux_2ch.md
Name: tdm_demux_2ch

Overview:
- Receive-side counterpart of the 2:1 channel mux: takes the single interleaved stream (A slot, B slot, A, B, ...) produced by toggling the mux select, and splits it back into two registered channel outputs.
- Slot alignment uses a frame sync flag that marks each A sample.
- Tracks alignment with a small FSM, flags sync slips, and counts completed A/B pairs.
- Sits directly downstream of the mux datapath, feeding per-channel consumers.

Parameters:
- WIDTH, 8, sample width in bits.
- CNT_W, 8, width of frame_cnt; the counter wraps modulo 2^CNT_W.
- SYNC_EVERY, 1:
  - 1: every A slot must carry sync.
  - 0: sync is needed only to acquire alignment.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  interleaved sample stream.
- din_valid  input  1  din holds a sample this cycle.
- sync  input  1  qualifies din as the channel-A slot; ignored when din_valid=0.
- a  output  WIDTH  last captured channel-A sample.
- b  output  WIDTH  last captured channel-B sample.
- a_valid  output  1  one-cycle pulse when a updates.
- b_valid  output  1  one-cycle pulse when b updates.
- pair_valid  output  1  one-cycle pulse when an aligned A/B pair is complete.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- frame_cnt  output  CNT_W  count of completed pairs.
- locked  output  1  high when the FSM is not in HUNT.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM = HUNT.
- Reset mid-frame: any half-captured pair is discarded; the FSM re-acquires from HUNT.
- All outputs are registered. Latency is 1 cycle from the accepting clock edge to the output update and pulse.
- Pulses are high for exactly one cycle. a and b hold their value between captures.
- A cycle with din_valid=0 changes no state, leaves a and b unchanged, and produces no pulses.
- FSM states: HUNT, WANT_B, WANT_A.
- HUNT:
  - din_valid&sync: a<=din, a_valid=1, go to WANT_B.
  - din_valid&!sync: sample dropped, no error, stay in HUNT.
- WANT_B:
  - din_valid&!sync: b<=din, b_valid=1, pair_valid=1, frame_cnt+=1, go to WANT_A.
  - din_valid&sync (slip, A arrived twice): sync_err=1, a<=din, a_valid=1, stay in WANT_B. This resyncs onto the new A. No pair is counted.
- WANT_A:
  - din_valid&sync: a<=din, a_valid=1, go to WANT_B.
  - din_valid&!sync with SYNC_EVERY=1: sync_err=1, sample dropped, go to HUNT.
  - din_valid&!sync with SYNC_EVERY=0: accepted as A (a<=din, a_valid=1), go to WANT_B.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag. It does not clear on sync_err, only on reset.
- locked = (state != HUNT), registered together with the state.
- b_valid and pair_valid always assert in the same cycle.
- a_valid and b_valid are never high in the same cycle.

Decomposition:
- Shared package tdm_pkg:
  - state typedef: HUNT=2'b00, WANT_B=2'b01, WANT_A=2'b10.
  - default WIDTH/CNT_W constants, so the mux-side sequencer and this block agree on them.
- No sub-module is natural. Keep the FSM, capture registers and wrap counter in one module.
- Target size is about 150 lines.

Test Plan (all scenarios use WIDTH=8, CNT_W=8, SYNC_EVERY=1 unless stated otherwise):
1. Reset then clean stream:
   - Stimulus: (0x11,sync) (0x22) (0x33,sync) (0x44).
   - Required: a=0x11 then 0x33; b=0x22 then 0x44; pair_valid pulses twice; frame_cnt=2; sync_err never asserts; locked goes high 1 cycle after the first sample.
2. Valid gaps:
   - Stimulus: same stream as scenario 1, with din_valid=0 for 3 cycles between every sample, and sync=1 driven during the gaps.
   - Required: results identical to scenario 1, with no extra pulses.
3. Slip in WANT_B:
   - Stimulus: (0xA0,sync) (0xA1,sync) (0xB1).
   - Required: sync_err pulses on the 0xA1 edge; a=0xA1; b=0xB1; frame_cnt=1.
4. Missing sync in WANT_A:
   - Stimulus: (0x01,sync) (0x02) (0x03).
   - Required: sync_err pulses on the 0x03 edge; locked drops to 0; a stays 0x01.
   - Repeat with SYNC_EVERY=0: a=0x03, no error.
5. Counter wrap:
   - Stimulus: 256 clean pairs.
   - Required: frame_cnt reads 0xFF after pair 255 and 0x00 after pair 256, with no error.
6. Async reset mid-frame:
   - Stimulus: assert rst_n low between the A and B slots, then release and send (0x55) (0x66,sync) (0x77).
   - Required: all outputs clear immediately, without waiting for a clock edge; 0x55 is dropped; a=0x66; b=0x77; frame_cnt=1.
